// File: rtl/z80_mmu_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : z80_mmu_loader_if
// Brief    : MMU register-port bus between the loader (master) and the MMU.
// Revision : 1.0
// ============================================================================
interface z80_mmu_loader_if;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cs_n, output wr_n, output addr, output wdata, input rdata);
    modport slave  (input cs_n, input wr_n, input addr, input wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/z80_mmu_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : z80_mmu_loader
// Brief    : Writes a 32-bit map into the four MMU page slots, optional read-back.
// Revision : 1.0
// ============================================================================
module z80_mmu_loader #(
    parameter int STROBE_CYCLES = 1,
    parameter bit VERIFY        = 1'b1
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    input  wire logic        i_start,
    input  wire logic [31:0] i_map,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    z80_mmu_loader_if.master mmu
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_VCHK   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0][7:0] map_q, map_d;
    logic [1:0]      k_q, k_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            cs_n_q, cs_n_d;
    logic            wr_n_q, wr_n_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            bus_active;

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    map_d   = i_map;
                    error_d = 1'b0;
                    k_d     = 2'd0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = STROBE_LAST;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (k_q != 2'd3) begin
                    k_d     = k_q + 2'd1;
                    state_d = S_SETUP;
                end else if (VERIFY) begin
                    k_d     = 2'd0;
                    state_d = S_VCHK;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_VCHK: begin
                // mmu.rdata reflects addr_q, which tracks k_q in this state
                if (mmu.rdata != map_q[k_q]) begin
                    error_d = 1'b1;
                end
                if (k_q == 2'd3) begin
                    state_d = S_FINISH;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state
        bus_active = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d     = (state_d == S_FINISH);
        cs_n_d     = !bus_active;
        wr_n_d     = (state_d != S_STROBE);
        addr_d     = busy_d ? k_d : 2'd0;
        data_d     = bus_active ? map_d[k_d] : 8'd0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            map_q   <= '0;
            k_q     <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= 2'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;
    assign mmu.cs_n  = cs_n_q;
    assign mmu.wr_n  = wr_n_q;
    assign mmu.addr  = addr_q;
    assign mmu.wdata = data_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_mmu_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_z80_mmu_loader
// Brief    : Scoreboard bench: dut 0 uses defaults, dut 1 STROBE_CYCLES=3/VERIFY=0.
// Revision : 1.0
// ============================================================================
module tb_z80_mmu_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] map_a = '0, map_b = '0;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic        corrupt = 1'b0;
    logic [7:0]  slot_a[4];
    logic [7:0]  slot_b[4];

    always #5 clk = ~clk;

    z80_mmu_loader_if ifa();
    z80_mmu_loader_if ifb();

    z80_mmu_loader #(.STROBE_CYCLES(1), .VERIFY(1'b1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_map(map_a),
        .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .mmu(ifa)
    );

    z80_mmu_loader #(.STROBE_CYCLES(3), .VERIFY(1'b0)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_map(map_b),
        .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .mmu(ifb)
    );

    // MMU models: commit on every edge with cs_n=0 and wr_n=0
    always @(posedge clk) begin
        if (!ifa.cs_n && !ifa.wr_n) slot_a[ifa.addr] <= ifa.wdata;
        if (!ifb.cs_n && !ifb.wr_n) slot_b[ifb.addr] <= ifb.wdata;
    end
    assign ifa.rdata = (corrupt && ifa.cs_n && busy_a && ifa.addr == 2'd2) ? 8'h00 : slot_a[ifa.addr];
    assign ifb.rdata = slot_b[ifb.addr];

    logic        s_cs[2], s_wr[2], s_busy[2], s_done[2], s_err[2];
    logic [1:0]  s_addr[2];
    logic [7:0]  s_data[2];
    logic [31:0] s_slots[2];
    assign s_cs[0] = ifa.cs_n;   assign s_cs[1] = ifb.cs_n;
    assign s_wr[0] = ifa.wr_n;   assign s_wr[1] = ifb.wr_n;
    assign s_addr[0] = ifa.addr; assign s_addr[1] = ifb.addr;
    assign s_data[0] = ifa.wdata; assign s_data[1] = ifb.wdata;
    assign s_busy[0] = busy_a;   assign s_busy[1] = busy_b;
    assign s_done[0] = done_a;   assign s_done[1] = done_b;
    assign s_err[0] = err_a;     assign s_err[1] = err_b;
    assign s_slots[0] = {slot_a[3], slot_a[2], slot_a[1], slot_a[0]};
    assign s_slots[1] = {slot_b[3], slot_b[2], slot_b[1], slot_b[0]};

    typedef struct { int dut; logic [1:0] addr; logic [7:0] data; int len; } wr_t;
    typedef struct { int dut; int lat; logic err; } dn_t;
    typedef struct { int kind; int dut; logic [31:0] val; } pl_t;

    wr_t wq[$];
    dn_t dq[$];
    pl_t pq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic       pwr[2] = '{1'b1, 1'b1};
    logic       pcs[2] = '{1'b1, 1'b1};
    logic [1:0] paddr[2];
    logic [7:0] pdata[2];
    int         run[2];
    int         elen[2];

    always @(negedge clk) begin : mon
        wr_t w;
        dn_t n;
        pl_t p;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                chk("reset_state",
                    32'({s_busy[d], s_done[d], s_err[d], s_cs[d], s_wr[d], s_addr[d], s_data[d]}),
                    32'({3'b000, 2'b11, 2'b00, 8'h00}));
                pwr[d] = 1'b1;
                pcs[d] = 1'b1;
                run[d] = 0;
            end else begin
                if (!s_wr[d]) chk("cs_during_wr", 32'(s_cs[d]), 32'd0);
                if (!s_wr[d] && pwr[d]) begin
                    if (wq.size() == 0 || wq[0].dut != d) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: dut %0d got addr %0d data %0h, required none",
                                 d, s_addr[d], s_data[d]);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(s_addr[d]), 32'(w.addr));
                        chk("wr_data", 32'(s_data[d]), 32'(w.data));
                        elen[d] = w.len;
                    end
                    chk("setup_stable", 32'({pcs[d], paddr[d], pdata[d]}), 32'({1'b0, s_addr[d], s_data[d]}));
                    run[d] = 1;
                end else if (!s_wr[d]) begin
                    run[d]++;
                    chk("strobe_stable", 32'({paddr[d], pdata[d]}), 32'({s_addr[d], s_data[d]}));
                end else if (!pwr[d]) begin
                    chk("strobe_len", 32'(run[d]), 32'(elen[d]));
                    chk("hold_stable", 32'({s_cs[d], s_addr[d], s_data[d]}), 32'({1'b0, paddr[d], pdata[d]}));
                end
                if (s_done[d]) begin
                    if (dq.size() == 0 || dq[0].dut != d) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: dut %0d got done=1, required none", d);
                    end else begin
                        n = dq.pop_front();
                        chk("done_latency", 32'(cyc - e0[d] + 1), 32'(n.lat));
                        chk("done_error", 32'(s_err[d]), 32'(n.err));
                        chk("busy_at_done", 32'(s_busy[d]), 32'd0);
                    end
                end
                pwr[d]   = s_wr[d];
                pcs[d]   = s_cs[d];
                paddr[d] = s_addr[d];
                pdata[d] = s_data[d];
            end
        end
        if (pq.size() != 0) begin
            p = pq.pop_front();
            case (p.kind)
                0: chk("slots", s_slots[p.dut], p.val);
                1: chk("error_flag", 32'(s_err[p.dut]), 32'(p.val[0]));
                default: begin
                    chk("writes_left", 32'(wq.size()), 32'd0);
                    chk("dones_left", 32'(dq.size()), 32'd0);
                end
            endcase
        end
    end

    task automatic exp_writes(input int d, input logic [31:0] m, input int cnt, input int len);
        for (int i = 0; i < cnt; i++) wq.push_back('{d, 2'(i), m[i*8 +: 8], len});
    endtask

    task automatic exp_done(input int d, input int lat, input logic err);
        dq.push_back('{d, lat, err});
    endtask

    // Leaves the caller 1 time unit into cycle 1 after the accepting edge
    task automatic start_load(input int d, input logic [31:0] m);
        @(negedge clk);
        if (d == 0) begin map_a = m; start_a = 1'b1; end
        else begin map_b = m; start_b = 1'b1; end
        e0[d] = cyc + 1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        exp_writes(0, 32'hC3C1C0E0, 4, 1);
        exp_done(0, 17, 1'b0);
        start_load(0, 32'hC3C1C0E0);
        cycles(20);
        pq.push_back('{0, 0, 32'hC3C1C0E0});

        // Starts during cycle 5 and during the FINISH cycle must be dropped
        exp_writes(0, 32'h5A6B7C8D, 4, 1);
        exp_done(0, 17, 1'b0);
        start_load(0, 32'h5A6B7C8D);
        repeat (4) @(posedge clk);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        cycles(10);

        corrupt = 1'b1;
        exp_writes(0, 32'h11223344, 4, 1);
        exp_done(0, 17, 1'b1);
        start_load(0, 32'h11223344);
        cycles(20);
        corrupt = 1'b0;
        cycles(3);
        pq.push_back('{1, 0, 32'd1});
        cycles(2);

        exp_writes(0, 32'h0F1E2D3C, 4, 1);
        exp_done(0, 17, 1'b0);
        start_load(0, 32'h0F1E2D3C);
        pq.push_back('{1, 0, 32'd0});
        repeat (17) @(posedge clk);
        exp_writes(0, 32'hFFFFFFFF, 4, 1);
        exp_done(0, 17, 1'b0);
        start_load(0, 32'hFFFFFFFF);
        cycles(20);
        pq.push_back('{0, 0, 32'hFFFFFFFF});
        cycles(2);

        // Reset lands in the STROBE cycle of slot 1; only slot 0 completes
        exp_writes(0, 32'hAABBCCDD, 1, 1);
        start_load(0, 32'hAABBCCDD);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycles(25);
        exp_writes(0, 32'h01020304, 4, 1);
        exp_done(0, 17, 1'b0);
        start_load(0, 32'h01020304);
        cycles(20);
        pq.push_back('{0, 0, 32'h01020304});
        cycles(2);

        exp_writes(1, 32'h89ABCDEF, 4, 3);
        exp_done(1, 21, 1'b0);
        start_load(1, 32'h89ABCDEF);
        cycles(25);
        pq.push_back('{0, 1, 32'h89ABCDEF});
        cycles(2);
        pq.push_back('{2, 0, 32'd0});
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
